// File: rtl/uart_cfg_pkg.sv
// Shared types and constants for the configurable UART receive path.
// Frame state, per-word status bundle and oversampling sample points.
package uart_cfg_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    STOP2,
    LINE_WAIT
  } rx_state_e;

  typedef struct packed {
    logic brk;
    logic frame_err;
    logic parity_err;
  } rx_user_t;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] SAMPLE_LO  = 4'd7;
  localparam logic [3:0] SAMPLE_HI  = 4'd9;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_fifo.sv
// sync_fifo: first-word fall-through FIFO with occupancy count.
// Ports: wr_i/din_i push, rd_i pop, dout_o head (0 when empty), valid_o, full_o, count_o.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     rd_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PONE = 1;
  localparam logic [AW:0]   CONE = 1;
  localparam logic [AW:0]   CMAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      cnt_q;
  logic             empty, pop, push;

  assign empty = (cnt_q == '0);
  assign full_o = (cnt_q == CMAX);
  assign pop = rd_i & ~empty;
  // a pop frees the slot, so a push into a full FIFO is legal then
  assign push = wr_i & (~full_o | pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + PONE;
      if (pop) rp_q <= rp_q + PONE;
      if (push && !pop) cnt_q <= cnt_q + CONE;
      else if (pop && !push) cnt_q <= cnt_q - CONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= din_i;
  end

  assign dout_o  = empty ? '0 : mem_q[rp_q];
  assign valid_o = ~empty;
  assign count_o = cnt_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable 16x-oversampled UART receiver with FIFO.
// Ports: rxd/baud_div/cfg_* in, m_t* stream out, rts/overflow flow status.
module uart_rx_cfg
  import uart_cfg_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int FIFO_DEPTH  = 16,
  parameter int RTS_MARGIN  = 4,
  parameter int DIV_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rxd,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       cfg_data_bits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  output logic [7:0]       m_tdata,
  output logic [2:0]       m_tuser,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             rts,
  output logic             overflow,
  input  logic             clr_overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] RTS_LVL =
    CW'(FIFO_DEPTH - RTS_MARGIN);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [DIV_W-1:0] DONE = 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s, rxd_prev_q;
  rx_state_e              state_q;
  logic [DIV_W-1:0]       cnt_q;
  logic [3:0]             tidx_q;
  logic                   s7_q, s8_q;
  logic [2:0]             bidx_q, last_idx;
  logic [1:0]             dbits_q;
  parity_e                par_q;
  logic                   stop2_q, par_en, par_exp;
  logic [7:0]             data_q, wdata_q;
  logic                   perr_q, ferr_q, brk_q;
  logic                   wr_q, ovf_q, rts_q;
  rx_user_t               wuser_q;
  logic                   tick, decide, bit_v;
  logic                   full, drop;
  logic [10:0]            fifo_dout;
  logic [CW-1:0]          fifo_cnt;

  assign rxd_s    = sync_q[SYNC_STAGES-1];
  assign tick     = (state_q != IDLE) && (cnt_q == '0);
  assign decide   = tick && (tidx_q == SAMPLE_HI);
  assign bit_v    = maj3(s7_q, s8_q, rxd_s);
  assign last_idx = {1'b0, dbits_q} + 3'd4;
  assign par_en   = (par_q == EVEN) || (par_q == ODD);
  assign par_exp  = (^data_q) ^ (par_q == ODD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q     <= '1;
      rxd_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      tidx_q     <= '0;
      s7_q       <= 1'b1;
      s8_q       <= 1'b1;
      bidx_q     <= '0;
      dbits_q    <= '0;
      par_q      <= NONE;
      stop2_q    <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      wuser_q    <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rxd};
      rxd_prev_q <= rxd_s;
      wr_q       <= 1'b0;
      // divider held reloaded while idle so ticks align to the start edge
      if (state_q == IDLE) begin
        cnt_q  <= baud_div;
        tidx_q <= '0;
      end else begin
        cnt_q <= tick ? baud_div : cnt_q - DONE;
        if (tick) begin
          tidx_q <= (tidx_q == LAST_TICK) ? '0 : tidx_q + 4'd1;
          if (tidx_q == SAMPLE_LO) s7_q <= rxd_s;
          if (tidx_q == SAMPLE_LO + 4'd1) s8_q <= rxd_s;
        end
      end
      unique case (state_q)
        IDLE: begin
          if (rxd_prev_q && !rxd_s) begin
            state_q <= START;
            dbits_q <= cfg_data_bits;
            par_q   <= (cfg_parity == 2'd1) ? EVEN :
                       (cfg_parity == 2'd2) ? ODD : NONE;
            stop2_q <= cfg_stop2;
            data_q  <= '0;
            bidx_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b1;
          end
        end
        START: begin
          if (decide) state_q <= bit_v ? IDLE : DATA;
        end
        DATA: begin
          if (decide) begin
            data_q[bidx_q] <= bit_v;
            brk_q <= brk_q & ~bit_v;
            if (bidx_q == last_idx)
              state_q <= par_en ? PARITY : STOP;
            else
              bidx_q <= bidx_q + 3'd1;
          end
        end
        PARITY: begin
          if (decide) begin
            perr_q  <= bit_v ^ par_exp;
            brk_q   <= brk_q & ~bit_v;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (decide) begin
            if (stop2_q) begin
              ferr_q  <= ~bit_v;
              brk_q   <= brk_q & ~bit_v;
              state_q <= STOP2;
            end else begin
              wr_q    <= 1'b1;
              wdata_q <= data_q;
              wuser_q <= '{brk: brk_q & ~bit_v,
                           frame_err: ~bit_v,
                           parity_err: perr_q};
              state_q <= bit_v ? IDLE : LINE_WAIT;
            end
          end
        end
        STOP2: begin
          if (decide) begin
            wr_q    <= 1'b1;
            wdata_q <= data_q;
            wuser_q <= '{brk: brk_q,
                         frame_err: ferr_q | ~bit_v,
                         parity_err: perr_q};
            state_q <= bit_v ? IDLE : LINE_WAIT;
          end
        end
        LINE_WAIT: begin
          if (rxd_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH(11),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_i   (wr_q),
    .din_i  ({wuser_q, wdata_q}),
    .rd_i   (m_tready),
    .dout_o (fifo_dout),
    .valid_o(m_tvalid),
    .full_o (full),
    .count_o(fifo_cnt)
  );

  assign drop = wr_q & full & ~m_tready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      rts_q <= 1'b0;
    end else begin
      if (drop) ovf_q <= 1'b1;
      else if (clr_overflow) ovf_q <= 1'b0;
      rts_q <= (fifo_cnt >= RTS_LVL);
    end
  end

  assign m_tdata  = fifo_dout[7:0];
  assign m_tuser  = fifo_dout[10:8];
  assign rts      = rts_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg with an expected-word scoreboard.
// Frames are driven bit by bit; words are popped and compared on arrival.
module tb_uart_rx_cfg;

  localparam int SYNC = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rxd;
  logic [15:0] baud_div;
  logic [1:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic [7:0]  m_tdata;
  logic [2:0]  m_tuser;
  logic        m_tvalid;
  logic        m_tready;
  logic        rts;
  logic        overflow;
  logic        clr_overflow;

  logic [10:0] exp_q[$];
  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int t_start = 0;
  int t_rise = 0;
  logic vld_prev = 1'b0;

  uart_rx_cfg #(
    .SYNC_STAGES(SYNC),
    .FIFO_DEPTH(16),
    .RTS_MARGIN(4),
    .DIV_W(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rxd          (rxd),
    .baud_div     (baud_div),
    .cfg_data_bits(cfg_data_bits),
    .cfg_parity   (cfg_parity),
    .cfg_stop2    (cfg_stop2),
    .m_tdata      (m_tdata),
    .m_tuser      (m_tuser),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .rts          (rts),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_tvalid && !vld_prev) t_rise = cyc;
    vld_prev = m_tvalid;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bits(input logic v, input int n, input int g);
    for (int i = 0; i < n; i++) begin
      rxd = (i == g) ? ~v : v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb,
                            input int par, input bit s2,
                            input bit pflip, input bit st1,
                            input bit st2, input int gbit,
                            input int goff, input int idle,
                            input bit push);
    logic [7:0] dm;
    logic [2:0] u;
    logic       pb;
    int         bc;
    bc = 16 * (int'(baud_div) + 1);
    dm = d & 8'((1 << nb) - 1);
    cfg_data_bits = 2'(nb - 5);
    cfg_parity = 2'(par);
    cfg_stop2 = s2;
    pb = (par == 2) ? ~^dm : ^dm;
    pb = pb ^ pflip;
    u[2] = (dm == 8'h00) && (par == 0 || !pb) && !st1;
    u[1] = !st1 || (s2 && !st2);
    u[0] = (par != 0) && pflip;
    if (push) exp_q.push_back({u, dm});
    t_start = cyc;
    drive_bits(1'b0, bc, -1);
    for (int i = 0; i < nb; i++)
      drive_bits(dm[i], bc, (i == gbit) ? goff : -1);
    if (par != 0) drive_bits(pb, bc, -1);
    drive_bits(st1, bc, -1);
    if (s2) drive_bits(st2, bc, -1);
    rxd = 1'b1;
    if (idle > 0) drive_bits(1'b1, idle * bc, -1);
  endtask

  task automatic expect_word(input string tag);
    logic [10:0] e;
    int n;
    n = 0;
    @(negedge clk);
    while (!m_tvalid && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(m_tvalid), 32'd1);
    if (m_tvalid) begin
      check({tag, "_sb"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({tag, "_data"}, 32'(m_tdata), 32'(e[7:0]));
        check({tag, "_user"}, 32'(m_tuser), 32'(e[10:8]));
      end
      m_tready = 1'b1;
    end
    @(posedge clk);
    #1;
    m_tready = 1'b0;
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    rxd = 1'b1;
    baud_div = 16'd3;
    cfg_data_bits = 2'd3;
    cfg_parity = 2'd0;
    cfg_stop2 = 1'b0;
    m_tready = 1'b0;
    clr_overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata", 32'(m_tdata), 32'd0);
    check("rst_tuser", 32'(m_tuser), 32'd0);
    check("rst_rts", 32'(rts), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    drive_bits(1'b1, 20, -1);

    // 8N1 0xA5 and start-to-valid latency
    send_frame(8'hA5, 8, 0, 0, 0, 1, 1, -1, 0, 1, 1);
    lat = SYNC + 1 + 4 * (16 * 9 + 10) + 1;
    check("lat_8n1", 32'(t_rise - t_start), 32'(lat));
    expect_word("a5");

    // 7E1 good then bad parity
    send_frame(8'h35, 7, 1, 0, 0, 1, 1, -1, 0, 1, 1);
    send_frame(8'h35, 7, 1, 0, 1, 1, 1, -1, 0, 1, 1);
    expect_word("7e1_ok");
    expect_word("7e1_bad");

    // 5O2 with second stop bit low
    send_frame(8'h15, 5, 2, 1, 0, 1, 0, -1, 0, 2, 1);
    expect_word("5o2_ferr");

    // break: 300-clock low pulse at fastest baud
    baud_div = 16'd0;
    cfg_data_bits = 2'd3;
    cfg_parity = 2'd0;
    cfg_stop2 = 1'b0;
    exp_q.push_back({3'b110, 8'h00});
    drive_bits(1'b0, 300, -1);
    drive_bits(1'b1, 64, -1);
    expect_word("break");
    check("brk_single", 32'(m_tvalid), 32'd0);
    send_frame(8'h5A, 8, 0, 0, 0, 1, 1, -1, 0, 1, 1);
    expect_word("after_brk");

    // false start and majority-vote glitches
    baud_div = 16'd3;
    drive_bits(1'b0, 20, -1);
    drive_bits(1'b1, 128, -1);
    check("false_start", 32'(m_tvalid), 32'd0);
    send_frame(8'hA5, 8, 0, 0, 0, 1, 1, 0, 40, 1, 1);
    expect_word("glitch_t9");
    send_frame(8'h3C, 8, 0, 0, 0, 1, 1, 2, 36, 1, 1);
    expect_word("glitch_t8");

    // fill, rts, overflow, back-to-back frames
    baud_div = 16'd0;
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 8, 0, 0, 0, 1, 1, -1, 0, 0, i < 16);
      if (i == 10) check("rts_11", 32'(rts), 32'd0);
      if (i == 11) check("rts_12", 32'(rts), 32'd1);
      if (i == 15) check("ovf_16", 32'(overflow), 32'd0);
    end
    check("ovf_17", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) expect_word("drain");
    check("drained", 32'(m_tvalid), 32'd0);
    check("rts_low", 32'(rts), 32'd0);
    check("ovf_hold", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    @(posedge clk);
    #1;
    clr_overflow = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);

    // reset mid-frame
    send_frame(8'h77, 8, 0, 0, 0, 1, 1, -1, 0, 1, 0);
    check("pre_rst_valid", 32'(m_tvalid), 32'd1);
    drive_bits(1'b0, 16, -1);
    drive_bits(1'b1, 16, -1);
    drive_bits(1'b0, 8, -1);
    rxd = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mrst_tvalid", 32'(m_tvalid), 32'd0);
    check("mrst_tdata", 32'(m_tdata), 32'd0);
    check("mrst_tuser", 32'(m_tuser), 32'd0);
    check("mrst_rts", 32'(rts), 32'd0);
    check("mrst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    drive_bits(1'b1, 64, -1);
    send_frame(8'hC3, 8, 0, 0, 0, 1, 1, -1, 0, 1, 1);
    expect_word("c3");
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
